data_mem_param: RTL and testbench

//  Parametrised, synchronous-read data memory for the custom-ISA datapath; successor to the fixed 1Kx16 data memory.

---
 rtl/data_mem_pkg.sv | 16 +
 rtl/data_mem_if.sv | 36 +++
 rtl/data_mem_array.sv | 32 +++
 rtl/data_mem_param.sv | 136 +++++++++++++
 tb/tb_data_mem_param.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the parametrised data memory.
// Optional parity storage is enabled by defining DATA_MEM_PARITY_EN.
package data_mem_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t CLEAR = 1'b1;

  // Even parity: stored bit makes the byte plus parity bit have an even number of ones.
  function automatic logic even_par(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// Request/response bundle for data_mem_param (master = load/store side, slave = memory).
// The perr response exists only when DATA_MEM_PARITY_EN is defined.
interface data_mem_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024
);
  import data_mem_pkg::*;

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned BE_W   = DATA_W / BYTE_W;

  logic              clear;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              busy_clr;
`ifdef DATA_MEM_PARITY_EN
  logic              perr;

  modport master (output clear, req, we, addr, be, wdata,
                  input  ready, rvalid, rdata, busy_clr, perr);
  modport slave  (input  clear, req, we, addr, be, wdata,
                  output ready, rvalid, rdata, busy_clr, perr);
`else
  modport master (output clear, req, we, addr, be, wdata,
                  input  ready, rvalid, rdata, busy_clr);
  modport slave  (input  clear, req, we, addr, be, wdata,
                  output ready, rvalid, rdata, busy_clr);
`endif

endinterface

// File: rtl/data_mem_array.sv
// Lane-enabled synchronous-read RAM with no reset, so it maps onto block RAM.
// The read register only loads on re, holding its value across writes.
module data_mem_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned LANE_W = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_W/LANE_W-1:0]   be,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);
  localparam int unsigned LANES = DATA_W / LANE_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (be[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_param.sv
// Parametrised data memory: clear sequencer FSM, req/ready handshake and 1-cycle reads.
// Define DATA_MEM_PARITY_EN to store one even-parity bit per byte and report perr.
module data_mem_param
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024
) (
  input logic       clk,
  input logic       reset,
  data_mem_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned NB     = DATA_W / BYTE_W;
`ifdef DATA_MEM_PARITY_EN
  localparam int unsigned LANE_W = BYTE_W + 1;
`else
  localparam int unsigned LANE_W = BYTE_W;
`endif
  localparam int unsigned ARR_W  = NB * LANE_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rvalid_q;
  logic              rd_seen_q;
  logic              take_clear, accept_rd, accept_wr;

  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [NB-1:0]     arr_be;
  logic [ARR_W-1:0]  arr_wdata, arr_rdata, wr_lanes;
  logic [DATA_W-1:0] rd_word;
  logic              rd_perr;

  assign bus.ready    = (state_q == IDLE);
  assign bus.busy_clr = (state_q == CLEAR);

  // clear wins over req in the same cycle; the request is simply dropped
  assign take_clear = bus.ready & bus.clear;
  assign accept_rd  = bus.ready & ~bus.clear & bus.req & ~bus.we;
  assign accept_wr  = bus.ready & ~bus.clear & bus.req & bus.we;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (take_clear) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rvalid_q  <= accept_rd;
      if (accept_rd) rd_seen_q <= 1'b1;
    end
  end

  // Pack write bytes (plus parity) into array lanes; unpack and check on the read side.
  always_comb begin
    wr_lanes = '0;
    rd_word  = '0;
    rd_perr  = 1'b0;
    for (int i = 0; i < int'(NB); i++) begin
      wr_lanes[i*LANE_W +: BYTE_W] = bus.wdata[i*BYTE_W +: BYTE_W];
      rd_word[i*BYTE_W +: BYTE_W]  = arr_rdata[i*LANE_W +: BYTE_W];
`ifdef DATA_MEM_PARITY_EN
      wr_lanes[i*LANE_W + BYTE_W] = even_par(bus.wdata[i*BYTE_W +: BYTE_W]);
      rd_perr = rd_perr | (arr_rdata[i*LANE_W + BYTE_W] ^
                           even_par(arr_rdata[i*LANE_W +: BYTE_W]));
`endif
    end
  end

  always_comb begin
    arr_re = accept_rd;
    if (state_q == CLEAR) begin
      arr_we    = 1'b1;
      arr_addr  = clr_cnt_q;
      arr_be    = '1;
      arr_wdata = '0;
    end else begin
      arr_we    = accept_wr;
      arr_addr  = bus.addr;
      arr_be    = bus.be;
      arr_wdata = wr_lanes;
    end
  end

  data_mem_array #(
    .DATA_W (ARR_W),
    .DEPTH  (DEPTH),
    .LANE_W (LANE_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .be    (arr_be),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // The array read register has no reset; rd_seen_q makes rdata read as zero until the first read.
  assign bus.rdata  = rd_seen_q ? rd_word : '0;
  assign bus.rvalid = rvalid_q;
`ifdef DATA_MEM_PARITY_EN
  assign bus.perr   = rvalid_q & rd_perr;
`else
  logic unused_perr;
  assign unused_perr = rd_perr;
`endif

endmodule

// File: tb/tb_data_mem_param.sv
// Self-checking bench for data_mem_param (DEPTH=16, DATA_W=16) with a read scoreboard.
// The parity scenario is built only when DATA_MEM_PARITY_EN is defined.
module tb_data_mem_param;
  localparam int unsigned DW     = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  data_mem_param #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int            checks = 0;
  int            errors = 0;
  exp_t          sb[$];
  logic [DW-1:0] model [DEPTH];

  always @(negedge clk) begin : monitor
    exp_t e;
    logic gp;
    if (reset === 1'b0 && bus.rvalid === 1'b1) begin
`ifdef DATA_MEM_PARITY_EN
      gp = bus.perr;
`else
      gp = 1'b0;
`endif
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid got rdata=%h with no read outstanding", bus.rdata);
      end else begin
        e = sb.pop_front();
        if (bus.rdata !== e.data || gp !== e.perr) begin
          errors++;
          $display("FAIL read_data got rdata=%h perr=%b expected rdata=%h perr=%b",
                   bus.rdata, gp, e.data, e.perr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_ready(input int exp_cycles, input string name);
    int n = 0;
    logic bad = 1'b0;
    while (bus.ready !== 1'b1 && n < 40) begin
      if (bus.busy_clr !== 1'b1) bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != exp_cycles) begin
      errors++;
      $display("FAIL %s_cycles got %0d cycles with ready=0 expected %0d", name, n, exp_cycles);
    end
    checks++;
    if (bad || bus.busy_clr !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy got busy_clr=%b at end (or low during clear) expected 0",
               name, bus.busy_clr);
    end
    for (int a = 0; a < int'(DEPTH); a++) model[a] = '0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [1:0] b);
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready got ready=%b expected 1", bus.ready);
    end
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = ADDR_W'(a); bus.wdata = d; bus.be = b;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = 1'b0;
    for (int i = 0; i < 2; i++) if (b[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
    checks++;
    if (bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rvalid got rvalid=%b after write expected 0", bus.rvalid);
    end
  endtask

  task automatic rd_exp(input int a, input logic [DW-1:0] d, input logic p);
    sb.push_back('{data: d, perr: p});
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = ADDR_W'(a);
    @(posedge clk); #1;
    bus.req = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rd_latency addr %0d got rvalid=%b one cycle after request expected 1",
               a, bus.rvalid);
    end
  endtask

  task automatic rd(input int a);
    rd_exp(a, model[a], 1'b0);
  endtask

  task automatic drain(input string name);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d reads outstanding expected 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.clear = 1'b0; bus.req = 1'b0; bus.we = 1'b0;
    bus.addr = '0; bus.be = '0; bus.wdata = '0;
    #12;
    checks++;
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", bus.ready); end
    checks++;
    if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b expected 0", bus.rvalid); end
    checks++;
    if (bus.busy_clr !== 1'b1) begin errors++; $display("FAIL reset_busy got %b expected 1", bus.busy_clr); end
    checks++;
    if (bus.rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h expected 0", bus.rdata); end
    @(posedge clk); #1;
    reset = 1'b0;
    wait_ready(int'(DEPTH), "reset_clear");
    for (int a = 0; a < int'(DEPTH); a++) rd(a);
    drain("reset_reads");
  endtask

  task automatic test_full_write();
    wr(5, 16'hA5C3, 2'b11);
    rd(5);
    drain("full_write");
  endtask

  task automatic test_partial_write();
    wr(5, 16'hFFFF, 2'b01);
    rd(5);
    wr(9, 16'h1234, 2'b00);
    rd(9);
    drain("partial_write");
  endtask

  task automatic test_back_to_back();
    wr(1, 16'd11, 2'b11);
    wr(2, 16'd22, 2'b11);
    wr(3, 16'd33, 2'b11);
    rd(1); rd(2); rd(3);
    wr(7, 16'hBEEF, 2'b11);
    rd(7);
    rd(5);
    drain("back_to_back");
  endtask

  task automatic test_rdata_hold();
    wr(5, 16'h0000, 2'b11);
    checks++;
    if (bus.rdata !== 16'hA5FF) begin
      errors++;
      $display("FAIL rdata_hold got rdata=%h after write expected a5ff", bus.rdata);
    end
  endtask

  task automatic test_clear_priority();
    wr(15, 16'h5A5A, 2'b11);
    rd(15);
    drain("clear_setup");
    bus.clear = 1'b1; bus.req = 1'b1; bus.we = 1'b0; bus.addr = ADDR_W'(15);
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.req = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b0 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority got rvalid=%b ready=%b expected 0 0", bus.rvalid, bus.ready);
    end
    wait_ready(int'(DEPTH), "clear");
    checks++;
    if (bus.rdata !== 16'h5A5A) begin
      errors++;
      $display("FAIL clear_rdata_hold got rdata=%h expected 5a5a", bus.rdata);
    end
    for (int a = 0; a < int'(DEPTH); a++) rd(a);
    drain("clear_reads");
  endtask

  task automatic test_reset_mid_clear();
    wr(4, 16'h1234, 2'b11);
    rd(4);
    drain("midclr_setup");
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    checks++;
    if (bus.ready !== 1'b0 || bus.busy_clr !== 1'b1 || bus.rdata !== '0) begin
      errors++;
      $display("FAIL midclr_reset got ready=%b busy_clr=%b rdata=%h expected 0 1 0000",
               bus.ready, bus.busy_clr, bus.rdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    wait_ready(int'(DEPTH), "midclr_restart");
    for (int a = 0; a < int'(DEPTH); a++) rd(a);
    drain("midclr_reads");
  endtask

`ifdef DATA_MEM_PARITY_EN
  task automatic test_parity();
    wr(6, 16'h1234, 2'b11);
    wr(8, 16'h00F0, 2'b11);
    dut.u_array.mem[6][0] = ~dut.u_array.mem[6][0];
    rd_exp(6, 16'h1235, 1'b1);
    rd(8);
    drain("parity");
  endtask
`endif

  initial begin
    test_reset();
    test_full_write();
    test_partial_write();
    test_back_to_back();
    test_rdata_hold();
    test_clear_priority();
    test_reset_mid_clear();
`ifdef DATA_MEM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
